// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix in one extra cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               sgn_op;
    logic               neg_a;
    logic               neg_b;
    logic               b_zero;
    logic               dz_q;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sh;

    logic               start_acc;
    logic               mt_ok;
    logic               last;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_r;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]   sh_nx;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_nx;
    logic [WIDTH-1:0]   lo_nx;

    assign start_acc = start && (state == S_IDLE || state == S_DONE);
    assign mt_ok     = !busy && !start_acc;
    assign last      = (count == CW'(WIDTH - 1));
    assign abs_a     = (!op[0] && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (!op[0] && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start) state_nx = S_CALC;
            S_CALC: if (last) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = start ? S_CALC : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        unique case (state)
            S_CALC, S_FIX: busy = 1'b1;
            S_DONE: begin
                done        = 1'b1;
                div_by_zero = dz_q;
            end
            default: ;
        endcase
    end

    // One iteration: multiply shifts the product right, divide shifts the remainder left
    always_comb begin
        mul_sum  = {1'b0, acc} + (sh[0] ? {1'b0, mag} : '0);
        div_r    = {acc, sh[WIDTH-1]};
        div_diff = div_r - {1'b0, mag};
        if (is_div) begin
            acc_nx = div_diff[WIDTH] ? div_r[WIDTH-1:0] : div_diff[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_nx = mul_sum[WIDTH:1];
            sh_nx  = {mul_sum[0], sh[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {acc, sh};
        prod_fix = (sgn_op && (neg_a ^ neg_b)) ? -prod : prod;
        quo_fix  = (sgn_op && (neg_a ^ neg_b)) ? -sh : sh;
        rem_fix  = (sgn_op && neg_a) ? -acc : acc;
        if (b_zero) quo_fix = '1;
        if (is_div) begin
            hi_nx = rem_fix;
            lo_nx = quo_fix;
        end else begin
            hi_nx = prod_fix[2*WIDTH-1:WIDTH];
            lo_nx = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            is_div <= 1'b0;
            sgn_op <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            dz_q   <= 1'b0;
            mag    <= '0;
            acc    <= '0;
            sh     <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (start_acc) begin
                count  <= '0;
                is_div <= op[1];
                sgn_op <= ~op[0];
                neg_a  <= ~op[0] & a[WIDTH-1];
                neg_b  <= ~op[0] & b[WIDTH-1];
                b_zero <= (b == '0);
                acc    <= '0;
                mag    <= op[1] ? abs_b : abs_a;
                sh     <= op[1] ? abs_a : abs_b;
            end else if (state == S_CALC) begin
                count <= count + CW'(1);
                acc   <= acc_nx;
                sh    <= sh_nx;
            end
            if (state == S_FIX) begin
                hi   <= hi_nx;
                lo   <= lo_nx;
                dz_q <= is_div & b_zero;
            end else if (mt_ok) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Arithmetic reference model plus directed literal cases and random traffic.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 30)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_op(input logic [1:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] up;
        sx = $signed(x);
        sy = $signed(y);
        ref_op = '0;
        case (o)
            2'd0: begin
                q = sx * sy;
                ref_op = {1'b0, q};
            end
            2'd1: begin
                up = {32'd0, x} * {32'd0, y};
                ref_op = {1'b0, up};
            end
            default: begin
                if (y == 0) begin
                    ref_op = {1'b1, x, 32'hFFFF_FFFF};
                end else if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    ref_op = {1'b0, r[31:0], q[31:0]};
                end else begin
                    ref_op = {1'b0, x % y, x / y};
                end
            end
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dz;
    int          m_rem;
    logic [64:0] p_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0;
            m_lo <= '0;
            m_rem <= 0;
            m_done <= 1'b0;
            m_dz <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) {m_dz, m_hi, m_lo} <= p_res;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                p_res <= ref_op(op, a, b);
                m_rem <= 33;
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_rem > 0);
        chk("done", done, m_done);
        chk("div_by_zero", div_by_zero, m_done & m_dz);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    task automatic drive(input logic st, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic hw, input logic lw,
                         input logic [31:0] wd);
        @(negedge clk);
        #1;
        start = st; op = o; a = x; b = y;
        hi_we = hw; lo_we = lw; wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic edz);
        int n;
        int nb;
        drive(1'b1, o, x, y, 1'b0, 1'b0, '0);
        n = 0;
        nb = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) break;
            #1 start = 1'b0;
        end
        start = 1'b0;
        chk({nm, " latency"}, 64'(n - 1), 64'd33);
        chk({nm, " busy cycles"}, 64'(nb), 64'd33);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        chk({nm, " dz"}, div_by_zero, edz);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: pick = 32'd0;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h8000_0000;
            3: pick = $urandom % 16;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        #1 rst_n = 1'b1;

        run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult -7*3", 2'd0, 32'hFFFF_FFF9, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu by 0", 2'd3, 32'h1234, 32'd0,
               32'h1234, 32'hFFFF_FFFF, 1'b1);
        run_op("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0);
        run_op("div -9/0", 2'd2, 32'hFFFF_FFF7, 32'd0,
               32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);

        drive(1'b1, 2'd1, 32'd6, 32'd7, 1'b0, 1'b0, '0);
        repeat (9) idle();
        drive(1'b1, 2'd2, 32'd99, 32'd3, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle();
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ignored start done", done, 1);
        chk("ignored start hi", hi, 32'd0);
        chk("ignored start lo", lo, 32'd42);
        drive(1'b0, 2'd0, '0, '0, 1'b1, 1'b0, 32'hA5A5_A5A5);
        idle();
        chk("mthi hi", hi, 32'hA5A5_A5A5);
        chk("mthi lo", lo, 32'd42);
        chk("mthi done", done, 0);

        drive(1'b1, 2'd2, 32'd1000, 32'd7, 1'b0, 1'b0, '0);
        repeat (14) idle();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset hi", hi, 0);
        chk("mid reset lo", lo, 0);
        chk("mid reset done", done, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_op("after reset", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        for (int i = 0; i < 6000; i++) begin
            drive(($urandom % 6) == 0, 2'($urandom), pick(), pick(),
                  ($urandom % 8) == 0, ($urandom % 8) == 0, $urandom);
            rst_n = ($urandom % 1500) != 0;
        end
        rst_n = 1'b1;
        repeat (40) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
